// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the frame state encoding plus width and bit-period helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = UART_DATA_W + 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Index width that never collapses to zero bits for a single requester
    function automatic int id_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request after the last winner,
// wrapping modulo NUM_REQ.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]           req,
    input  logic [id_width(NUM_REQ)-1:0] last,
    output logic                         found,
    output logic [id_width(NUM_REQ)-1:0] winner
);

    localparam int GW = id_width(NUM_REQ);

    logic [GW-1:0] idx_s;
    int            sum_s;

    // Scan from farthest to nearest so the closest set bit after last wins
    always_comb begin
        found  = 1'b0;
        winner = {GW{1'b0}};
        idx_s  = {GW{1'b0}};
        sum_s  = 32'sd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum_s = int'(last) + k;
            idx_s = GW'(sum_s % NUM_REQ);
            if (req[idx_s]) begin
                found  = 1'b1;
                winner = idx_s;
            end else begin
                found  = found;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one 8N1 UART serializer among NUM_REQ byte producers using
// round-robin arbitration; all outputs come straight from flops.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 10_000_000,
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = UART_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [id_width(NUM_REQ)-1:0] grant_id,
    output logic                         tx,
    output logic                         busy
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int GW  = id_width(NUM_REQ);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_W) + 1;

    localparam logic [CW-1:0]      CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE   = CW'(32'd1);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(CPB - 1);
    localparam logic [BW-1:0]      BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0]      BIT_ONE   = BW'(32'd1);
    localparam logic [BW-1:0]      BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [GW-1:0]      LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_NONE  = {NUM_REQ{1'b0}};
    localparam logic [NUM_REQ-1:0] REQ_ONE   = NUM_REQ'(32'd1);

    uart_state_e         state_r;
    logic [CW-1:0]       cnt_r;
    logic [BW-1:0]       bit_idx_r;
    logic [DATA_W-1:0]   shift_r;
    logic [GW-1:0]       last_r;
    logic                tx_r;
    logic                busy_r;
    logic [NUM_REQ-1:0]  ready_r;
    logic [GW-1:0]       grant_r;

    logic                found_s;
    logic [GW-1:0]       winner_s;
    logic [DATA_W-1:0]   data_sel_s;
    logic [DATA_W-1:0]   shift_nx_s;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .last   (last_r),
        .found  (found_s),
        .winner (winner_s)
    );

    // Select the winning requester's byte without a variable-width part-select
    always_comb begin
        data_sel_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == GW'(i)) begin
                data_sel_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                data_sel_s = data_sel_s;
            end
        end
    end

    // Next shift-register contents at a data-bit boundary
    always_comb begin
        shift_nx_s = shift_r >> 32'd1;
    end

    // Frame FSM: arbitration, bit timing and serialization
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= BIT_ZERO;
            shift_r   <= {DATA_W{1'b0}};
            last_r    <= LAST_INIT;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            ready_r   <= REQ_NONE;
            grant_r   <= {GW{1'b0}};
        end else begin
            ready_r <= REQ_NONE;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        shift_r   <= data_sel_s;
                        grant_r   <= winner_s;
                        last_r    <= winner_s;
                        ready_r   <= REQ_ONE << winner_s;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        bit_idx_r <= BIT_ZERO;
                        state_r   <= START;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        tx_r      <= shift_r[0];
                        bit_idx_r <= BIT_ZERO;
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (bit_idx_r == BIT_LAST) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            shift_r   <= shift_nx_s;
                            tx_r      <= shift_nx_s[0];
                            bit_idx_r <= bit_idx_r + BIT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_r;
    assign grant_id  = grant_r;
    assign tx        = tx_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: vector table, corner sequences and randomized
// traffic against a round-robin / frame-shape reference model.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int CPB  = 10;
    localparam int CPB1 = 2;
    localparam int FB   = UART_FRAME_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        tx, busy;

    logic        v1;
    logic [7:0]  d1;
    logic        r1, g1, tx1, busy1;

    int  checks = 0;
    int  errors = 0;
    time prev_start = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .NUM_REQ(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .tx(tx), .busy(busy));

    uart_tx_sched #(.CLK_FREQ(100_000_000), .BAUD(50_000_000), .NUM_REQ(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1),
        .req_ready(r1), .grant_id(g1), .tx(tx1), .busy(busy1));

    typedef struct {
        logic [3:0] vec;
        int         id;
        logic [7:0] data;
    } vec_t;

    typedef struct {
        logic [3:0] start_vec;
        int         start_id;
        logic [3:0] next_vec;
        int         next_id;
    } rst_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first pending requester after the previous winner
    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // Wait for a grant, then follow the whole frame cycle by cycle
    task automatic expect_frame(input int id, input logic [7:0] data, input bit b2b,
                                input bit withdraw, input int abort_at);
        int         w;
        int         mism;
        logic [9:0] fr;
        logic [9:0] seen;
        logic [3:0] onehot;
        time        t0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (req_ready == 4'b0000 && w < 200);
        if (req_ready == 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout got none expected requester %0d", id);
            return;
        end
        t0 = $time;
        check("latency", w, b2b ? 2 : 1);
        if (b2b) check("start_spacing", int'((t0 - prev_start) / 10), (FB * CPB) + 1);
        prev_start = t0;
        check("grant_id", grant_id, id);
        req_valid[id] = 1'b0;
        fr     = {1'b1, data, 1'b0};
        seen   = 10'd0;
        onehot = 4'b0001 << id;
        mism   = 0;
        for (int c = 0; c < FB * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (c == abort_at) begin
                rst = 1'b1;
                check("pre_abort_cycles", mism, 0);
                return;
            end
            if (withdraw && c == 20) req_valid[3] = 1'b1;
            if (withdraw && c == 90) req_valid[3] = 1'b0;
            if (c % CPB == CPB / 2) seen[c / CPB] = tx;
            if (tx !== fr[c / CPB]) mism++;
            if (busy !== 1'b1) mism++;
            if (req_ready !== ((c == 0) ? onehot : 4'b0000)) mism++;
            if (grant_id !== 2'(id)) mism++;
        end
        check("frame_bits", seen, fr);
        check("frame_cycles", mism, 0);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {busy, tx, req_ready}, {1'b0, 1'b1, 4'b0000});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [7];
        rst_vec_t   rtbl [2];
        logic [7:0] data_m [4];
        logic [3:0] newbits;
        int         last_m;
        int         win;
        int         w;
        int         mism;
        logic [9:0] fr;

        tbl[0] = '{4'b0001, 0, 8'hA5};
        tbl[1] = '{4'b0100, 2, 8'h3C};
        tbl[2] = '{4'b0011, 0, 8'h00};
        tbl[3] = '{4'b1010, 1, 8'hFF};
        tbl[4] = '{4'b1000, 3, 8'h81};
        tbl[5] = '{4'b1111, 0, 8'h5A};
        tbl[6] = '{4'b0110, 1, 8'h96};
        rtbl[0] = '{4'b0001, 0, 4'b1010, 1};
        rtbl[1] = '{4'b0100, 2, 4'b1001, 0};

        rst = 1'b1; req_valid = 4'b0000; req_data = 32'd0; v1 = 1'b0; d1 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", {tx, busy, req_ready, grant_id}, {1'b1, 1'b0, 4'b0000, 2'b00});
        check("reset_state_1", {tx1, busy1, r1, g1}, {1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            req_data = {4{~tbl[i].data}};
            req_data[tbl[i].id*8 +: 8] = tbl[i].data;
            req_valid = tbl[i].vec;
            expect_frame(tbl[i].id, tbl[i].data, 1'b0, 1'b0, -1);
            req_valid = 4'b0000;
            check_idle("idle_after_frame");
        end

        // Reset in the middle of data bit 3, then a fresh arbitration round
        for (int i = 0; i < 2; i++) begin
            req_data = 32'hC3_96_5A_E1;
            req_valid = rtbl[i].start_vec;
            expect_frame(rtbl[i].start_id, req_data[rtbl[i].start_id*8 +: 8], 1'b0, 1'b0, 45);
            @(negedge clk);
            check("abort_state", {tx, busy, req_ready, grant_id}, {1'b1, 1'b0, 4'b0000, 2'b00});
            rst = 1'b0;
            req_valid = rtbl[i].next_vec;
            expect_frame(rtbl[i].next_id, req_data[rtbl[i].next_id*8 +: 8], 1'b0, 1'b0, -1);
            req_valid = 4'b0000;
            check_idle("idle_after_abort");
        end

        // Request raised and withdrawn while the line is busy is never served
        req_valid = 4'b0001;
        expect_frame(0, req_data[7:0], 1'b0, 1'b1, -1);
        req_valid = 4'b0000;
        mism = 0;
        repeat (30) begin
            @(negedge clk);
            if (req_ready !== 4'b0000 || tx !== 1'b1 || busy !== 1'b0) mism++;
        end
        check("withdraw_idle", mism, 0);

        // Saturation: all four pending, each re-raises after its grant
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_m[i] = 8'h10 + 8'(i);
            req_data[i*8 +: 8] = data_m[i];
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expect_frame(k % 4, data_m[k % 4], k > 0, 1'b0, -1);
            data_m[k % 4] = 8'($urandom);
            req_data[(k % 4)*8 +: 8] = data_m[k % 4];
            req_valid[k % 4] = 1'b1;
        end
        req_valid = 4'b0000;
        check_idle("idle_after_saturation");

        // Randomized back-to-back traffic against the reference model
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        last_m = 3;
        for (int i = 0; i < 4; i++) begin
            data_m[i] = 8'($urandom);
            req_data[i*8 +: 8] = data_m[i];
        end
        req_valid = 4'($urandom_range(1, 15));
        for (int n = 0; n < 20; n++) begin
            win = rr_pick(req_valid, last_m);
            expect_frame(win, data_m[win], n > 0, 1'b0, -1);
            last_m = win;
            if ($urandom_range(0, 3) == 0) req_valid[$urandom_range(0, 3)] = 1'b0;
            newbits = 4'($urandom) & ~req_valid;
            if ((req_valid | newbits) == 4'b0000) newbits[$urandom_range(0, 3)] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (newbits[i]) begin
                    data_m[i] = 8'($urandom);
                    req_data[i*8 +: 8] = data_m[i];
                end
            end
            req_valid = req_valid | newbits;
        end
        req_valid = 4'b0000;
        check_idle("idle_after_random");

        // Single-requester build at two clocks per bit
        for (int j = 0; j < 3; j++) begin
            d1 = (j == 0) ? 8'h3C : 8'($urandom);
            v1 = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (r1 !== 1'b1 && w < 50);
            check("single_latency", w, 1);
            v1 = 1'b0;
            fr = {1'b1, d1, 1'b0};
            mism = 0;
            for (int c = 0; c < FB * CPB1; c++) begin
                if (c > 0) @(negedge clk);
                if (tx1 !== fr[c / CPB1] || busy1 !== 1'b1 || g1 !== 1'b0) mism++;
                if (r1 !== (c == 0)) mism++;
            end
            check("single_frame_cycles", mism, 0);
            @(negedge clk);
            check("single_frame_end", {busy1, tx1}, {1'b0, 1'b1});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
